// File: rtl/bus_ram_slave.sv
// Word-addressed on-chip RAM target for the shared multiplexed bus.
// Single/burst reads and byte-masked writes; out-of-window bursts end in error.
module bus_ram_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addrData_i,
  input  logic [3:0]  bus_byteEnables_i,
  input  logic [7:0]  bus_burstSize_i,
  input  logic        bus_readNWrite_i,
  input  logic        bus_beginTransaction_i,
  input  logic        bus_endTransaction_i,
  input  logic        bus_dataValid_i,
  output logic [31:0] bus_addrData_o,
  output logic        bus_endTransaction_o,
  output logic        bus_dataValid_o,
  output logic        bus_busy_o,
  output logic        bus_error_o
);

  localparam int AW    = DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int SW    = AW + 9;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_ERR,
    RD_ISSUE,
    RD_DATA,
    RD_ERR
  } state_t;

  state_t        state_q;
  logic [AW-1:0] off_q;
  logic [7:0]    rem_q;
  logic [8:0]    wr_left_q;
  logic          err_q;
  logic          dv_q;
  logic          end_q;
  logic          busy_q;
  logic          berr_q;
  logic [31:0]   rdata_q;

  logic [31:0]   mem [DEPTH];

  logic          hit;
  logic [AW-1:0] offset;
  logic [SW-1:0] span;
  logic          range_err;
  logic          wr_ok;
  logic          ram_re;

  assign hit    = bus_addrData_i[31:AW+2] == BASE_ADDR[31:AW+2];
  assign offset = bus_addrData_i[AW+1:2];

  // Full-width sum so a burst can never wrap past the top of the window.
  assign span = SW'(offset) + SW'(bus_burstSize_i) + SW'(1);
  assign range_err = span > SW'(DEPTH);

  assign wr_ok = (state_q == WR_DATA) && bus_dataValid_i &&
                 !err_q && (wr_left_q != '0);

  assign ram_re = (state_q == RD_ISSUE) ||
                  ((state_q == RD_DATA) && (rem_q != '0));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (bus_byteEnables_i[k]) begin
          mem[off_q][8*k +: 8] <= bus_addrData_i[8*k +: 8];
        end
      end
    end
    if (ram_re) begin
      rdata_q <= mem[off_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      off_q     <= '0;
      rem_q     <= '0;
      wr_left_q <= '0;
      err_q     <= 1'b0;
      dv_q      <= 1'b0;
      end_q     <= 1'b0;
      busy_q    <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      end_q  <= 1'b0;
      berr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus_beginTransaction_i && hit) begin
            off_q     <= offset;
            rem_q     <= bus_burstSize_i;
            wr_left_q <= {1'b0, bus_burstSize_i} + 9'd1;
            err_q     <= range_err;
            if (!bus_readNWrite_i) begin
              state_q <= WR_DATA;
            end else if (range_err) begin
              state_q <= RD_ERR;
              berr_q  <= 1'b1;
              end_q   <= 1'b1;
            end else begin
              state_q <= RD_ISSUE;
              busy_q  <= 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (bus_dataValid_i) begin
            if (wr_ok) begin
              off_q     <= off_q + 1'b1;
              wr_left_q <= wr_left_q - 9'd1;
            end else begin
              err_q <= 1'b1;
            end
            if (bus_endTransaction_i) begin
              if (wr_ok) begin
                state_q <= IDLE;
              end else begin
                state_q <= WR_ERR;
                berr_q  <= 1'b1;
              end
            end
          end
        end
        WR_ERR: begin
          state_q <= IDLE;
        end
        RD_ISSUE: begin
          dv_q    <= 1'b1;
          end_q   <= (rem_q == 8'd0);
          off_q   <= off_q + 1'b1;
          state_q <= RD_DATA;
        end
        RD_DATA: begin
          if (rem_q == 8'd0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            dv_q  <= 1'b1;
            end_q <= (rem_q == 8'd1);
            rem_q <= rem_q - 8'd1;
            off_q <= off_q + 1'b1;
          end
        end
        RD_ERR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_addrData_o       = dv_q ? rdata_q : 32'h0;
  assign bus_dataValid_o      = dv_q;
  assign bus_endTransaction_o = end_q;
  assign bus_busy_o           = busy_q;
  assign bus_error_o          = berr_q;

endmodule

// File: tb/tb_bus_ram_slave.sv
// Directed bench for bus_ram_slave: single/burst/byte-lane access,
// range errors, address misses and asynchronous reset mid-burst.
module tb_bus_ram_slave;

  typedef logic [31:0] w4_t [4];

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i;
  logic [3:0]  be_i;
  logic [7:0]  bs_i;
  logic        rnw_i;
  logic        begin_i;
  logic        end_i;
  logic        dv_i;
  logic [31:0] data_o;
  logic        end_o;
  logic        dv_o;
  logic        busy_o;
  logic        err_o;
  logic [3:0]  fl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign fl = {dv_o, end_o, busy_o, err_o};

  bus_ram_slave dut (
    .clk                    (clk),
    .rst                    (rst),
    .bus_addrData_i         (addr_i),
    .bus_byteEnables_i      (be_i),
    .bus_burstSize_i        (bs_i),
    .bus_readNWrite_i       (rnw_i),
    .bus_beginTransaction_i (begin_i),
    .bus_endTransaction_i   (end_i),
    .bus_dataValid_i        (dv_i),
    .bus_addrData_o         (data_o),
    .bus_endTransaction_o   (end_o),
    .bus_dataValid_o        (dv_o),
    .bus_busy_o             (busy_o),
    .bus_error_o            (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic [7:0] bs,
                       input logic rnw);
    addr_i  = a;
    bs_i    = bs;
    rnw_i   = rnw;
    begin_i = 1'b1;
    tick();
    begin_i = 1'b0;
    addr_i  = 32'h0;
    bs_i    = 8'h0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a,
                    input logic [7:0] bs, input int n, input w4_t d,
                    input logic [3:0] be, input logic experr);
    start(a, bs, 1'b0);
    for (int i = 0; i < n; i++) begin
      addr_i = d[i];
      be_i   = be;
      dv_i   = 1'b1;
      end_i  = (i == n - 1);
      tick();
      if (i < n - 1) chk({tag, "_beat"}, 32'(fl), 32'h0);
    end
    dv_i   = 1'b0;
    end_i  = 1'b0;
    be_i   = 4'h0;
    addr_i = 32'h0;
    chk({tag, "_end"}, 32'(fl), experr ? 32'h1 : 32'h0);
    tick();
    chk({tag, "_idle"}, 32'(fl), 32'h0);
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input int bs, input w4_t e);
    start(a, 8'(bs), 1'b1);
    chk({tag, "_t1_flags"}, 32'(fl), 32'h2);
    chk({tag, "_t1_data"}, data_o, 32'h0);
    for (int i = 0; i <= bs; i++) begin
      tick();
      chk({tag, "_beat_flags"}, 32'(fl),
          32'({1'b1, (i == bs), 1'b1, 1'b0}));
      chk({tag, "_beat_data"}, data_o, e[i]);
    end
    tick();
    chk({tag, "_done_flags"}, 32'(fl), 32'h0);
    chk({tag, "_done_data"}, data_o, 32'h0);
  endtask

  initial begin
    rst     = 1'b1;
    addr_i  = 32'h0;
    be_i    = 4'h0;
    bs_i    = 8'h0;
    rnw_i   = 1'b0;
    begin_i = 1'b0;
    end_i   = 1'b0;
    dv_i    = 1'b0;
    tick();
    tick();
    chk("reset_flags", 32'(fl), 32'h0);
    chk("reset_data", data_o, 32'h0);
    rst = 1'b0;
    tick();

    wr("wr_single", 32'h1000_0010, 8'd0, 1,
       '{32'hDEAD_BEEF, 0, 0, 0}, 4'hF, 1'b0);
    rd("rd_single", 32'h1000_0010, 0, '{32'hDEAD_BEEF, 0, 0, 0});

    wr("wr_full", 32'h1000_0000, 8'd0, 1,
       '{32'h1122_3344, 0, 0, 0}, 4'hF, 1'b0);
    wr("wr_lanes", 32'h1000_0000, 8'd0, 1,
       '{32'hAABB_CCDD, 0, 0, 0}, 4'b0101, 1'b0);
    rd("rd_lanes", 32'h1000_0000, 0, '{32'h11BB_33DD, 0, 0, 0});

    wr("wr_burst", 32'h1000_0FF0, 8'd3, 4,
       '{32'h0, 32'h1, 32'h2, 32'h3}, 4'hF, 1'b0);
    rd("rd_burst", 32'h1000_0FF0, 3, '{32'h0, 32'h1, 32'h2, 32'h3});

    start(32'h1000_0FFC, 8'd1, 1'b1);
    chk("rderr_t1_flags", 32'(fl), 32'h5);
    chk("rderr_t1_data", data_o, 32'h0);
    tick();
    chk("rderr_t2_flags", 32'(fl), 32'h0);

    wr("wr_range", 32'h1000_0FFC, 8'd1, 2,
       '{32'h5555_5555, 32'h6666_6666, 0, 0}, 4'hF, 1'b1);
    rd("rd_after_range", 32'h1000_0FFC, 0, '{32'h3, 0, 0, 0});

    wr("wr_overrun", 32'h1000_0004, 8'd0, 2,
       '{32'hCAFE_F00D, 32'h1234_5678, 0, 0}, 4'hF, 1'b1);
    rd("rd_overrun", 32'h1000_0004, 0, '{32'hCAFE_F00D, 0, 0, 0});

    wr("wr_short", 32'h1000_0008, 8'd3, 1,
       '{32'h0BAD_CAFE, 0, 0, 0}, 4'hF, 1'b0);
    rd("rd_short", 32'h1000_0008, 0, '{32'h0BAD_CAFE, 0, 0, 0});

    start(32'h2000_0000, 8'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("miss_rd_flags", 32'(fl), 32'h0);
      chk("miss_rd_data", data_o, 32'h0);
      tick();
    end

    start(32'h0000_0000, 8'd0, 1'b0);
    addr_i = 32'hFFFF_FFFF;
    be_i   = 4'hF;
    dv_i   = 1'b1;
    end_i  = 1'b1;
    tick();
    dv_i   = 1'b0;
    end_i  = 1'b0;
    be_i   = 4'h0;
    addr_i = 32'h0;
    for (int i = 0; i < 10; i++) begin
      chk("miss_wr_flags", 32'(fl), 32'h0);
      tick();
    end
    rd("rd_after_miss", 32'h1000_0000, 0, '{32'h11BB_33DD, 0, 0, 0});

    start(32'h1000_0FF0, 8'd3, 1'b1);
    tick();
    chk("rst_mid_beat0_flags", 32'(fl), 32'hA);
    chk("rst_mid_beat0_data", data_o, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_flags", 32'(fl), 32'h0);
    chk("rst_async_data", data_o, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_after_flags", 32'(fl), 32'h0);
    end
    rd("rd_after_rst", 32'h1000_0010, 0, '{32'hDEAD_BEEF, 0, 0, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_ram_slave.md
Name: bus_ram_slave

Overview:
- Word-addressed on-chip RAM responder for the shared multiplexed address/data bus. It is the target-side counterpart of the CPU bus master.
- It decodes a configurable address window and performs single and burst reads and writes, with per-byte write enables.
- It reports out-of-window bursts on the bus error line.
- It sits on the bus alongside the SPART. All of its outputs are zero whenever it is not driving, so they can be OR-combined onto the bus.

Parameters:
- BASE_ADDR, 32'h1000_0000, byte base address of the window; must be aligned to the window size.
- DEPTH_LOG2, 10, log2 of the number of 32-bit words (default 1024 words = 4 KiB window).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- bus_addrData_i  in  32  multiplexed address (begin beat) or write data (data beats).
- bus_byteEnables_i  in  4  byte lanes for writes; ignored for reads.
- bus_burstSize_i  in  8  beats minus one (0 = single word); sampled with begin.
- bus_readNWrite_i  in  1  1 = read, 0 = write; sampled with begin.
- bus_beginTransaction_i  in  1  address beat.
- bus_endTransaction_i  in  1  master's last write beat.
- bus_dataValid_i  in  1  write data beat valid.
- bus_addrData_o  out  32  read data; 0 when not driving.
- bus_endTransaction_o  out  1  last read beat, or error termination.
- bus_dataValid_o  out  1  read data beat valid.
- bus_busy_o  out  1  high while a read response is pending or streaming.
- bus_error_o  out  1  one-cycle error termination pulse.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; all outputs are 0 immediately.
  - RAM contents are not cleared.
  - A transaction in progress is abandoned. No partial beats or error are emitted after reset deasserts.
- Address decode:
  - Hit = addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2].
  - Word offset = addr[DEPTH_LOG2+1:2]; addr[1:0] is ignored.
  - A miss is ignored entirely: no state change, all outputs stay 0.
- Range check: a hit is a range error when offset + burstSize + 1 > 2^DEPTH_LOG2, computed at DEPTH_LOG2+9 bits with no wrap. Bursts never wrap around the window.
- Outputs are registered, with no combinational input-to-output paths.
- States:
  - IDLE: on beginTransaction and a hit, latch offset, remaining = burstSize, and the error flag. Go to WR_DATA (write), RD_ISSUE (read, no error) or RD_ERR (read, error). beginTransaction outside IDLE is ignored.
  - WR_DATA:
    - Each cycle with dataValid_i=1 is one beat.
    - If there is no error and beats accepted ≤ burstSize+1, write lanes with byteEnables_i[k]=1 into RAM[offset] and increment offset. Otherwise discard the beat and set the error flag (covers overrun).
    - On the beat with endTransaction_i=1: if error flag is set, go to WR_ERR; else go to IDLE.
    - A short burst (end before burstSize+1 beats) is legal and not an error.
    - bus_busy_o stays 0 in this state.
  - WR_ERR: bus_error_o=1 for exactly one cycle, the cycle after the master's end beat, then IDLE. bus_endTransaction_o stays 0.
  - RD_ISSUE: present RAM address (synchronous-read RAM); bus_busy_o=1; go to RD_DATA.
  - RD_DATA:
    - Drive one beat per cycle, back-to-back: dataValid_o=1, addrData_o=RAM word, offset++.
    - On the beat where remaining = 0, assert endTransaction_o=1, then go to IDLE.
    - bus_busy_o=1 throughout, deasserting in the cycle after the last beat.
  - RD_ERR: one cycle of error_o=1, endTransaction_o=1, dataValid_o=0, addrData_o=0; then IDLE.
- Read latency: with begin in cycle T, the first data beat is in cycle T+2 and the last is in T+2+burstSize. A read-error termination appears in T+1.
- Write latency: data is written at the edge ending each accepted beat. A read beginning in the cycle after a write's end beat returns the new data.
- Bus errors are never raised on address misses.

Test Plan:
- Reset, then single write of 0xDEADBEEF to 0x1000_0010 with be=F; single read of the same address → dataValid_o and endTransaction_o both 1 in T+2 with 0xDEADBEEF; busy_o=1 in T+1..T+2.
- Byte enables: write 0x11223344 (be=F) to 0x1000_0000, then 0xAABBCCDD with be=4'b0101 → read returns 0x11BB33DD.
- Burst: write 4 beats (burstSize=3) of 0,1,2,3 at 0x1000_0FF0, then burst read → 4 consecutive beats 0,1,2,3 in T+2..T+5, endTransaction_o only at T+5, all outputs 0 at T+6.
- Range error: read burstSize=1 at 0x1000_0FFC → T+1 error_o=1 and endTransaction_o=1, no dataValid_o. Write of the same → 2 beats absorbed, error_o=1 the cycle after end, RAM[0x3FF] unchanged.
- Miss: read at 0x2000_0000 and write at 0x0000_0000 → all outputs 0 for 10 cycles, RAM unchanged.
- Async reset asserted mid-way through a 4-beat read (after beat 1) → outputs 0 in the same cycle; after release, a new single read to 0x1000_0010 returns 0xDEADBEEF.
